ex_code: RTL and testbench

- Execute stage of the 5-stage RV32 pipeline, between decode (ID/EX outputs) and memory (EX/MEM inputs).
- Selects the ALU B operand, performs the ALU operation and resolves branch/jump redirect combinationally.
- Registers the control bits and data into the EX/MEM pipeline register.

---
 rtl/ex_code.sv | 134 +++++++++++++
 tb/tb_ex_code.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_code.sv
// ex_code: execute stage of the 5-stage RV32 pipeline.
// Picks the ALU B operand, runs the ALU, resolves the branch/jump redirect
// combinationally and registers the control and data into the EX/MEM register.
//
// Optional feature macro: EX_CODE_ALU_EXT_EN
//   When defined, ALU codes 100 (XOR), 110 (SLL) and 111 (SRL) are implemented.
//   When undefined, those codes produce 0.
//
// Ports:
//   clk, reset (async, active-low)  clock and reset of the EX/MEM register
//   *E inputs                       decode-side control and operands
//   *M outputs                      EX/MEM register (1-cycle latency)
//   PCSrcE, PCTargetE               combinational redirect request and target
module ex_code #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            RegWriteE,
    input  logic [1:0]      ResultSrcE,
    input  logic            MemWriteE,
    input  logic            JumpE,
    input  logic            BranchE,
    input  logic [2:0]      ALUControlE,
    input  logic            ALUSrcE,
    input  logic [XLEN-1:0] RD1E,
    input  logic [XLEN-1:0] RD2E,
    input  logic [XLEN-1:0] PCE,
    input  logic [4:0]      RdE,
    input  logic [XLEN-1:0] ImmExtE,
    input  logic [XLEN-1:0] PCPlus4E,
    output logic            RegWriteM,
    output logic [1:0]      ResultSrcM,
    output logic            MemWriteM,
    output logic [XLEN-1:0] ALUResultM,
    output logic [XLEN-1:0] WriteDataM,
    output logic [4:0]      RdM,
    output logic [XLEN-1:0] PCPlus4M,
    output logic            PCSrcE,
    output logic [XLEN-1:0] PCTargetE
);

    localparam int unsigned REG_W   = 5;
    localparam int unsigned SHAMT_W = 5;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_SRL = 3'b111;

    // EX/MEM pipeline register payload
    typedef struct packed {
        logic             reg_write;
        logic [1:0]       result_src;
        logic             mem_write;
        logic [XLEN-1:0]  alu_result;
        logic [XLEN-1:0]  write_data;
        logic [REG_W-1:0] rd;
        logic [XLEN-1:0]  pc_plus4;
    } exmem_t;

    logic [XLEN-1:0] src_a_c;
    logic [XLEN-1:0] src_b_c;
    logic [XLEN-1:0] alu_result_c;
    logic            alu_zero_c;
    exmem_t          exmem_d;
    exmem_t          exmem_q;

    // Operand selection
    assign src_a_c = RD1E;
    assign src_b_c = ALUSrcE ? ImmExtE : RD2E;

    // ALU; unimplemented codes yield 0
    always_comb begin
        alu_result_c = '0;
        case (ALUControlE)
            ALU_ADD: alu_result_c = src_a_c + src_b_c;
            ALU_SUB: alu_result_c = src_a_c - src_b_c;
            ALU_AND: alu_result_c = src_a_c & src_b_c;
            ALU_OR:  alu_result_c = src_a_c | src_b_c;
            ALU_SLT: alu_result_c = XLEN'($signed(src_a_c) < $signed(src_b_c));
`ifdef EX_CODE_ALU_EXT_EN
            ALU_XOR: alu_result_c = src_a_c ^ src_b_c;
            ALU_SLL: alu_result_c = src_a_c << src_b_c[SHAMT_W-1:0];
            ALU_SRL: alu_result_c = src_a_c >> src_b_c[SHAMT_W-1:0];
`else
            ALU_XOR: alu_result_c = '0;
            ALU_SLL: alu_result_c = '0;
            ALU_SRL: alu_result_c = '0;
`endif
            default: alu_result_c = '0;
        endcase
    end

    assign alu_zero_c = (alu_result_c == '0);

    // Redirect: a jump always redirects; a branch only when the compare is equal
    assign PCSrcE    = JumpE | (BranchE & alu_zero_c);
    assign PCTargetE = PCE + ImmExtE;

    // Next EX/MEM contents
    always_comb begin
        exmem_d            = '0;
        exmem_d.reg_write  = RegWriteE;
        exmem_d.result_src = ResultSrcE;
        exmem_d.mem_write  = MemWriteE;
        exmem_d.alu_result = alu_result_c;
        exmem_d.write_data = RD2E;
        exmem_d.rd         = RdE;
        exmem_d.pc_plus4   = PCPlus4E;
    end

    // EX/MEM register; reset clears write enables so nothing is written spuriously
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            exmem_q <= '0;
        end else begin
            exmem_q <= exmem_d;
        end
    end

    assign RegWriteM  = exmem_q.reg_write;
    assign ResultSrcM = exmem_q.result_src;
    assign MemWriteM  = exmem_q.mem_write;
    assign ALUResultM = exmem_q.alu_result;
    assign WriteDataM = exmem_q.write_data;
    assign RdM        = exmem_q.rd;
    assign PCPlus4M   = exmem_q.pc_plus4;

endmodule

// File: tb/tb_ex_code.sv
// Self-checking bench for ex_code: directed scenarios plus random vectors
// compared against a behavioural model of the execute stage.
module tb_ex_code;

    localparam int unsigned XLEN = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic            RegWriteE;
    logic [1:0]      ResultSrcE;
    logic            MemWriteE;
    logic            JumpE;
    logic            BranchE;
    logic [2:0]      ALUControlE;
    logic            ALUSrcE;
    logic [XLEN-1:0] RD1E, RD2E, PCE, ImmExtE, PCPlus4E;
    logic [4:0]      RdE;
    logic            RegWriteM;
    logic [1:0]      ResultSrcM;
    logic            MemWriteM;
    logic [XLEN-1:0] ALUResultM, WriteDataM, PCPlus4M;
    logic [4:0]      RdM;
    logic            PCSrcE;
    logic [XLEN-1:0] PCTargetE;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    ex_code #(.XLEN(XLEN)) dut (
        .clk(clk), .reset(reset),
        .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE),
        .JumpE(JumpE), .BranchE(BranchE), .ALUControlE(ALUControlE),
        .ALUSrcE(ALUSrcE), .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE), .RdE(RdE),
        .ImmExtE(ImmExtE), .PCPlus4E(PCPlus4E),
        .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .MemWriteM(MemWriteM),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .RdM(RdM),
        .PCPlus4M(PCPlus4M), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        reg_write;
        logic [1:0]  result_src;
        logic        mem_write;
        logic        jump;
        logic        branch;
        logic [2:0]  alu_ctrl;
        logic        alu_src;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [31:0] pc4;
    } vec_t;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Behavioural ALU: instruction semantics written as plain arithmetic
    function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic lt;
        lt = (a[31] != b[31]) ? a[31] : (a < b);
        if (op == 3'd0) return a + b;
        if (op == 3'd1) return a + ~b + 32'd1;
        if (op == 3'd2) return a & b;
        if (op == 3'd3) return a | b;
        if (op == 3'd5) return lt ? 32'd1 : 32'd0;
`ifdef EX_CODE_ALU_EXT_EN
        if (op == 3'd4) return a ^ b;
        if (op == 3'd6) return a << b[4:0];
        if (op == 3'd7) return a >> b[4:0];
`endif
        return 32'd0;
    endfunction

    function automatic vec_t zero_vec();
        vec_t v;
        v = '{default: '0};
        return v;
    endfunction

    function automatic vec_t rand_vec();
        vec_t v;
        v.reg_write  = 1'($urandom);
        v.result_src = 2'($urandom_range(0, 2));
        v.mem_write  = 1'($urandom);
        v.jump       = ($urandom_range(0, 3) == 0);
        v.branch     = 1'($urandom);
        v.alu_ctrl   = 3'($urandom);
        v.alu_src    = 1'($urandom);
        v.rd1        = $urandom;
        v.rd2        = ($urandom_range(0, 3) == 0) ? v.rd1 : $urandom;
        v.pc         = $urandom;
        v.rd         = 5'($urandom);
        v.imm        = $urandom;
        v.pc4        = v.pc + 32'd4;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        RegWriteE   = v.reg_write;
        ResultSrcE  = v.result_src;
        MemWriteE   = v.mem_write;
        JumpE       = v.jump;
        BranchE     = v.branch;
        ALUControlE = v.alu_ctrl;
        ALUSrcE     = v.alu_src;
        RD1E        = v.rd1;
        RD2E        = v.rd2;
        PCE         = v.pc;
        RdE         = v.rd;
        ImmExtE     = v.imm;
        PCPlus4E    = v.pc4;
    endtask

    function automatic logic [31:0] exp_result(input vec_t v);
        return ref_alu(v.alu_ctrl, v.rd1, v.alu_src ? v.imm : v.rd2);
    endfunction

    function automatic logic exp_pcsrc(input vec_t v);
        return v.jump || (v.branch && exp_result(v) == 32'd0);
    endfunction

    task automatic check_comb(input vec_t v);
        check("PCSrcE", {31'b0, PCSrcE}, {31'b0, exp_pcsrc(v)});
        check("PCTargetE", PCTargetE, v.pc + v.imm);
    endtask

    task automatic check_m(input vec_t v);
        check("RegWriteM", {31'b0, RegWriteM}, {31'b0, v.reg_write});
        check("ResultSrcM", {30'b0, ResultSrcM}, {30'b0, v.result_src});
        check("MemWriteM", {31'b0, MemWriteM}, {31'b0, v.mem_write});
        check("ALUResultM", ALUResultM, exp_result(v));
        check("WriteDataM", WriteDataM, v.rd2);
        check("RdM", {27'b0, RdM}, {27'b0, v.rd});
        check("PCPlus4M", PCPlus4M, v.pc4);
    endtask

    task automatic check_m_zero(input string tag);
        check({tag, "_RegWriteM"}, {31'b0, RegWriteM}, 32'd0);
        check({tag, "_ResultSrcM"}, {30'b0, ResultSrcM}, 32'd0);
        check({tag, "_MemWriteM"}, {31'b0, MemWriteM}, 32'd0);
        check({tag, "_ALUResultM"}, ALUResultM, 32'd0);
        check({tag, "_WriteDataM"}, WriteDataM, 32'd0);
        check({tag, "_RdM"}, {27'b0, RdM}, 32'd0);
        check({tag, "_PCPlus4M"}, PCPlus4M, 32'd0);
    endtask

    // Drive on the falling edge, check comb outputs, then registered outputs after the rising edge
    task automatic run_vec(input vec_t v);
        @(negedge clk);
        drive(v);
        #1;
        check_comb(v);
        @(posedge clk);
        #1;
        check_m(v);
    endtask

    initial begin
        vec_t v;

        // Reset held with arbitrary inputs and clock running
        reset = 1'b0;
        v = rand_vec();
        v.reg_write = 1'b1;
        v.mem_write = 1'b1;
        drive(v);
        repeat (3) @(posedge clk);
        #1;
        check_m_zero("rst_hold");

        // Release and capture on the following edge
        @(negedge clk);
        v.rd = 5'd5;
        drive(v);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst_rel_RegWriteM", {31'b0, RegWriteM}, 32'd1);
        check("rst_rel_RdM", {27'b0, RdM}, 32'd5);

        // Add immediate
        v = zero_vec();
        v.rd1 = 32'd10; v.imm = 32'd6; v.alu_src = 1'b1; v.alu_ctrl = 3'b000; v.rd = 5'd3;
        v.reg_write = 1'b1;
        run_vec(v);
        check("addi_result", ALUResultM, 32'd16);
        check("addi_rd", {27'b0, RdM}, 32'd3);

        // Sub and slt
        v = zero_vec();
        v.rd1 = 32'd5; v.rd2 = 32'd9; v.alu_ctrl = 3'b001;
        run_vec(v);
        check("sub_result", ALUResultM, 32'hFFFF_FFFC);
        v.alu_ctrl = 3'b101;
        run_vec(v);
        check("slt_result", ALUResultM, 32'd1);
        v.rd1 = 32'h8000_0000; v.rd2 = 32'd1;
        run_vec(v);
        check("slt_signed", ALUResultM, 32'd1);
        v.rd1 = 32'd1; v.rd2 = 32'h8000_0000;
        run_vec(v);
        check("slt_signed_rev", ALUResultM, 32'd0);

        // Branch taken / not taken
        v = zero_vec();
        v.branch = 1'b1; v.alu_ctrl = 3'b001; v.rd1 = 32'd7; v.rd2 = 32'd7;
        v.pc = 32'h20; v.imm = 32'hFFFF_FFF8;
        run_vec(v);
        check("beq_taken", {31'b0, PCSrcE}, 32'd1);
        check("beq_target", PCTargetE, 32'h18);
        v.rd2 = 32'd8;
        run_vec(v);
        check("beq_not_taken", {31'b0, PCSrcE}, 32'd0);

        // Jump with link
        v = zero_vec();
        v.jump = 1'b1; v.pc = 32'h40; v.imm = 32'h10; v.pc4 = 32'h44;
        v.result_src = 2'b10; v.reg_write = 1'b1; v.rd1 = 32'd1; v.rd2 = 32'd2;
        run_vec(v);
        check("jal_pcsrc", {31'b0, PCSrcE}, 32'd1);
        check("jal_target", PCTargetE, 32'h50);
        check("jal_pc4", PCPlus4M, 32'h44);
        check("jal_rsrc", {30'b0, ResultSrcM}, 32'd2);

        // Jump and branch together
        v.branch = 1'b1; v.alu_ctrl = 3'b001;
        run_vec(v);
        check("jal_beq_pcsrc", {31'b0, PCSrcE}, 32'd1);

        // Store
        v = zero_vec();
        v.mem_write = 1'b1; v.rd2 = 32'hDEAD_BEEF; v.alu_src = 1'b1; v.rd1 = 32'h100; v.imm = 32'h4;
        run_vec(v);
        check("sw_mw", {31'b0, MemWriteM}, 32'd1);
        check("sw_data", WriteDataM, 32'hDEAD_BEEF);

        // Extended ALU code 100
        v = zero_vec();
        v.alu_ctrl = 3'b100; v.rd1 = 32'hF0; v.rd2 = 32'hFF;
        run_vec(v);
`ifdef EX_CODE_ALU_EXT_EN
        check("xor_result", ALUResultM, 32'h0F);
`else
        check("xor_result", ALUResultM, 32'h00);
`endif

        // Random vectors against the model
        for (int i = 0; i < 300; i++) begin
            run_vec(rand_vec());
        end

        // Reset asserted mid-operation: register clears at once, comb path untouched
        @(negedge clk);
        v = rand_vec();
        v.reg_write = 1'b1;
        v.mem_write = 1'b1;
        drive(v);
        #2 reset = 1'b0;
        #1;
        check_m_zero("rst_mid");
        check_comb(v);
        @(posedge clk);
        #1;
        check_m_zero("rst_mid_edge");
        @(negedge clk);
        #1 reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            run_vec(rand_vec());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
